// File: rtl/ball_game_sequencer_pkg.sv
// Shared game definitions: display state encoding, frame-rate constants and ball start position.
package defines;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        PAUSED    = 3'd3,
        LOST      = 3'd4,
        LEVEL_UP  = 3'd5,
        GAME_OVER = 3'd6,
        WIN       = 3'd7
    } game_state_t;

    localparam int FRAME_RATE       = 60;
    localparam int LOST_FRAMES_DEF  = 60;
    localparam int LEVEL_FRAMES_DEF = 90;
    localparam int FRAME_CNT_W      = 8;

    localparam int INITIAL_X = 280;
    localparam int INITIAL_Y = 185;

endpackage

// File: rtl/ball_game_sequencer_if.sv
// Sequencer bus: keypad/collision inputs in, ball-control and display status out.
interface ball_game_sequencer_if;
    import defines::*;

    logic        startOfFrame;
    logic        key5IsPressed;
    logic        keyPauseIsPressed;
    logic        collisionSmileyBorderBottom;
    logic        collisionSmileyObstacleReal;
    logic        reset_level;
    logic        pause;
    logic [2:0]  lives;
    logic [13:0] score;
    logic [2:0]  level;
    logic [2:0]  gameState;

    modport master (
        output startOfFrame, key5IsPressed, keyPauseIsPressed,
               collisionSmileyBorderBottom, collisionSmileyObstacleReal,
        input  reset_level, pause, lives, score, level, gameState
    );

    modport slave (
        input  startOfFrame, key5IsPressed, keyPauseIsPressed,
               collisionSmileyBorderBottom, collisionSmileyObstacleReal,
        output reset_level, pause, lives, score, level, gameState
    );

endinterface

// File: rtl/ball_game_sequencer_frame_delay_counter.sv
// Counts startOfFrame pulses; done flags the pulse that reaches limit.
module frame_delay_counter
    import defines::*;
#(
    parameter int CNT_W = FRAME_CNT_W
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clear,
    input  logic             startOfFrame,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (startOfFrame)
            count <= count + 1'b1;
    end

    // A pulse seen while cleared is never counted, so the entry cycle is excluded.
    assign done = !clear && startOfFrame && (count == limit - 1'b1);

endmodule

// File: rtl/ball_game_sequencer.sv
// Game sequencer: owns lives/score/level and drives the ball controller's reset_level and pause.
module ball_game_sequencer
    import defines::*;
#(
    parameter int LIVES_INIT     = 3,
    parameter int HITS_PER_LEVEL = 8,
    parameter int POINTS_PER_HIT = 10,
    parameter int LOST_FRAMES    = LOST_FRAMES_DEF,
    parameter int LEVEL_FRAMES   = LEVEL_FRAMES_DEF,
    parameter int MAX_LEVEL      = 4,
    parameter int SCORE_MAX      = 9999
) (
    input  logic                  clk,
    input  logic                  resetN,
    ball_game_sequencer_if.slave  bus
);

    localparam int HITS_W = $clog2(HITS_PER_LEVEL + 1);

    game_state_t       state, stateNext;
    logic [2:0]        lives, livesNext;
    logic [13:0]       score, scoreNext;
    logic [2:0]        level, levelNext;
    logic [HITS_W-1:0] hits, hitsNext, hitCount;
    logic              key5D, keyPauseD;
    logic              firstCycle, resetLevel, pauseR;
    logic              key5Press, pausePress, levelDone, frameDone;
    logic              counterClear;
    logic [FRAME_CNT_W-1:0] frameLimit;

    function automatic logic [13:0] satScore(input logic [13:0] cur);
        logic [14:0] sum;
        sum = {1'b0, cur} + 15'(POINTS_PER_HIT);
        if (sum > 15'(SCORE_MAX))
            satScore = 14'(SCORE_MAX);
        else
            satScore = sum[13:0];
    endfunction

    assign key5Press  = bus.key5IsPressed && !key5D;
    assign pausePress = bus.keyPauseIsPressed && !keyPauseD;
    assign hitCount   = hits + 1'b1;
    assign levelDone  = bus.collisionSmileyObstacleReal && (hitCount == HITS_W'(HITS_PER_LEVEL));

    assign counterClear = firstCycle || !(state == LOST || state == LEVEL_UP);
    assign frameLimit   = (state == LOST) ? FRAME_CNT_W'(LOST_FRAMES) : FRAME_CNT_W'(LEVEL_FRAMES);

    frame_delay_counter #(.CNT_W(FRAME_CNT_W)) frameDelay (
        .clk          (clk),
        .resetN       (resetN),
        .clear        (counterClear),
        .startOfFrame (bus.startOfFrame),
        .limit        (frameLimit),
        .done         (frameDone)
    );

    always_comb begin
        stateNext = state;
        livesNext = lives;
        scoreNext = score;
        levelNext = level;
        hitsNext  = hits;
        case (state)
            IDLE: begin
                if (key5Press) begin
                    stateNext = SERVE;
                    livesNext = 3'(LIVES_INIT);
                    scoreNext = '0;
                    levelNext = 3'd1;
                    hitsNext  = '0;
                end
            end
            SERVE: begin
                if (key5Press)
                    stateNext = PLAY;
            end
            PLAY: begin
                // A non-completing hit is still scored when the ball is lost in the same cycle.
                if (bus.collisionSmileyObstacleReal) begin
                    scoreNext = satScore(score);
                    hitsNext  = hitCount;
                end
                if (levelDone)
                    stateNext = LEVEL_UP;
                else if (bus.collisionSmileyBorderBottom) begin
                    stateNext = LOST;
                    if (lives != 3'd0)
                        livesNext = lives - 3'd1;
                end else if (pausePress)
                    stateNext = PAUSED;
            end
            PAUSED: begin
                if (pausePress)
                    stateNext = PLAY;
            end
            LOST: begin
                if (frameDone)
                    stateNext = (lives == 3'd0) ? GAME_OVER : SERVE;
            end
            LEVEL_UP: begin
                if (frameDone) begin
                    if (level == 3'(MAX_LEVEL))
                        stateNext = WIN;
                    else begin
                        stateNext = SERVE;
                        levelNext = level + 3'd1;
                        hitsNext  = '0;
                    end
                end
            end
            default: begin
                if (key5Press)
                    stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            lives      <= 3'(LIVES_INIT);
            score      <= '0;
            level      <= 3'd1;
            hits       <= '0;
            key5D      <= 1'b0;
            keyPauseD  <= 1'b0;
            firstCycle <= 1'b0;
            resetLevel <= 1'b0;
            pauseR     <= 1'b1;
        end else begin
            state      <= stateNext;
            lives      <= livesNext;
            score      <= scoreNext;
            level      <= levelNext;
            hits       <= hitsNext;
            key5D      <= bus.key5IsPressed;
            keyPauseD  <= bus.keyPauseIsPressed;
            firstCycle <= (stateNext != state);
            resetLevel <= (stateNext != state) && (stateNext == SERVE || stateNext == IDLE);
            pauseR     <= (stateNext != PLAY);
        end
    end

    assign bus.reset_level = resetLevel;
    assign bus.pause       = pauseR;
    assign bus.lives       = lives;
    assign bus.score       = score;
    assign bus.level       = level;
    assign bus.gameState   = state;

endmodule

// File: tb/tb_ball_game_sequencer.sv
// Bench for ball_game_sequencer: directed game scenarios plus random play against a rule-level model.
module tb_ball_game_sequencer;
    import defines::*;

    localparam int LIVES_INIT = 3;
    localparam int HITS_LVL   = 8;
    localparam int PTS        = 10;
    localparam int LOST_F     = 60;
    localparam int LEVEL_F    = 90;
    localparam int MAX_LVL    = 4;
    localparam int SMAX       = 9999;
    localparam int SMAX2      = 25;

    logic clk = 1'b0;
    logic resetN;
    int   checks = 0;
    int   failures = 0;
    logic k5Lvl, kpLvl;

    ball_game_sequencer_if bus ();
    ball_game_sequencer_if bus2 ();

    always #5 clk = ~clk;

    ball_game_sequencer dut (.clk(clk), .resetN(resetN), .bus(bus));
    ball_game_sequencer #(.SCORE_MAX(SMAX2)) dutSat (.clk(clk), .resetN(resetN), .bus(bus2));

    assign bus2.startOfFrame                = bus.startOfFrame;
    assign bus2.key5IsPressed               = bus.key5IsPressed;
    assign bus2.keyPauseIsPressed           = bus.keyPauseIsPressed;
    assign bus2.collisionSmileyBorderBottom = bus.collisionSmileyBorderBottom;
    assign bus2.collisionSmileyObstacleReal = bus.collisionSmileyObstacleReal;

    game_state_t mState;
    int  mLives, mScore, mScore2, mLevel, mHits, mFrames;
    bit  mFirst, mK5d, mKpd, mResetLevel, mPause;

    task automatic checkValue(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mState = IDLE; mLives = LIVES_INIT; mScore = 0; mScore2 = 0; mLevel = 1;
        mHits = 0; mFrames = 0; mFirst = 0; mK5d = 0; mKpd = 0;
        mResetLevel = 0; mPause = 1;
    endtask

    // One clock of the game rules, in plain arithmetic.
    task automatic modelStep(input bit sof, input bit k5, input bit kp, input bit bot, input bit obs);
        bit k5p, kpp;
        game_state_t prev;
        k5p = k5 && !mK5d;
        kpp = kp && !mKpd;
        mK5d = k5; mKpd = kp;
        prev = mState;
        case (mState)
            IDLE: if (k5p) begin
                mState = SERVE; mLives = LIVES_INIT; mScore = 0; mScore2 = 0; mLevel = 1; mHits = 0;
            end
            SERVE: if (k5p) mState = PLAY;
            PLAY: begin
                if (obs) begin
                    mScore  = (mScore + PTS > SMAX) ? SMAX : mScore + PTS;
                    mScore2 = (mScore2 + PTS > SMAX2) ? SMAX2 : mScore2 + PTS;
                    mHits++;
                end
                if (obs && mHits == HITS_LVL) mState = LEVEL_UP;
                else if (bot) begin
                    mState = LOST;
                    if (mLives > 0) mLives--;
                end else if (kpp) mState = PAUSED;
            end
            PAUSED: if (kpp) mState = PLAY;
            LOST: if (!mFirst && sof) begin
                mFrames++;
                if (mFrames == LOST_F) mState = (mLives == 0) ? GAME_OVER : SERVE;
            end
            LEVEL_UP: if (!mFirst && sof) begin
                mFrames++;
                if (mFrames == LEVEL_F) begin
                    if (mLevel == MAX_LVL) mState = WIN;
                    else begin mState = SERVE; mLevel++; mHits = 0; end
                end
            end
            default: if (k5p) mState = IDLE;
        endcase
        mFirst = (mState != prev);
        if (mFirst) mFrames = 0;
        mResetLevel = mFirst && (mState == SERVE || mState == IDLE);
        mPause = (mState != PLAY);
    endtask

    task automatic compareAll();
        checkValue("gameState", int'(bus.gameState), int'(mState));
        checkValue("lives", int'(bus.lives), mLives);
        checkValue("score", int'(bus.score), mScore);
        checkValue("level", int'(bus.level), mLevel);
        checkValue("reset_level", int'(bus.reset_level), int'(mResetLevel));
        checkValue("pause", int'(bus.pause), int'(mPause));
        checkValue("score_sat", int'(bus2.score), mScore2);
    endtask

    task automatic step(input bit sof, input bit bot, input bit obs);
        @(negedge clk);
        bus.startOfFrame = sof;
        bus.key5IsPressed = k5Lvl;
        bus.keyPauseIsPressed = kpLvl;
        bus.collisionSmileyBorderBottom = bot;
        bus.collisionSmileyObstacleReal = obs;
        @(posedge clk);
        modelStep(sof, k5Lvl, kpLvl, bot, obs);
        #1;
        compareAll();
    endtask

    task automatic press5();
        k5Lvl = 1; step(0, 0, 0);
        k5Lvl = 0; step(0, 0, 0);
    endtask

    task automatic pressPause();
        kpLvl = 1; step(0, 0, 0);
        kpLvl = 0; step(0, 0, 0);
    endtask

    task automatic hitN(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 1);
            step(0, 0, 0);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0);
            step(0, 0, 0);
            step(1, 0, 0);
        end
    endtask

    task automatic asyncReset();
        @(posedge clk);
        #3;
        bus.startOfFrame = 0; bus.key5IsPressed = 0; bus.keyPauseIsPressed = 0;
        bus.collisionSmileyBorderBottom = 0; bus.collisionSmileyObstacleReal = 0;
        k5Lvl = 0; kpLvl = 0;
        resetN = 0;
        #1;
        modelReset();
        compareAll();
        checkValue("async_rst_state", int'(bus.gameState), int'(IDLE));
        checkValue("async_rst_pause", int'(bus.pause), 1);
        @(negedge clk);
        resetN = 1;
    endtask

    initial begin
        int pulses;
        bus.startOfFrame = 0; bus.key5IsPressed = 0; bus.keyPauseIsPressed = 0;
        bus.collisionSmileyBorderBottom = 0; bus.collisionSmileyObstacleReal = 0;
        k5Lvl = 0; kpLvl = 0;
        resetN = 0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        compareAll();
        checkValue("rst_lives", int'(bus.lives), 3);
        checkValue("rst_reset_level", int'(bus.reset_level), 0);
        @(negedge clk);
        resetN = 1;

        // Held key in IDLE: one transition, one reset_level pulse.
        pulses = 0;
        k5Lvl = 1;
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 0);
            if (i == 0) checkValue("serve_rl_first", int'(bus.reset_level), 1);
            if (bus.reset_level) pulses++;
        end
        checkValue("held_key_pulses", pulses, 1);
        checkValue("held_key_state", int'(bus.gameState), int'(SERVE));
        k5Lvl = 0; step(0, 0, 0);
        press5();
        checkValue("play_pause", int'(bus.pause), 0);

        for (int lv = 1; lv <= MAX_LVL; lv++) begin
            if (lv > 1) press5();
            hitN(8);
            checkValue("levelup_state", int'(bus.gameState), int'(LEVEL_UP));
            checkValue("levelup_score", int'(bus.score), 80 * lv);
            frames(LEVEL_F);
            if (lv < MAX_LVL) begin
                checkValue("next_level", int'(bus.level), lv + 1);
                checkValue("next_level_rl", int'(bus.reset_level), 1);
            end else
                checkValue("win_state", int'(bus.gameState), int'(WIN));
        end
        press5();
        checkValue("win_to_idle", int'(bus.gameState), int'(IDLE));

        press5();
        for (int i = 0; i < 3; i++) begin
            press5();
            step(0, 1, 0);
            checkValue("lost_lives", int'(bus.lives), 2 - i);
            frames(LOST_F);
        end
        checkValue("game_over", int'(bus.gameState), int'(GAME_OVER));
        press5();
        checkValue("go_to_idle", int'(bus.gameState), int'(IDLE));

        press5(); press5();
        hitN(7);
        step(0, 1, 1);
        checkValue("tie_levelup", int'(bus.gameState), int'(LEVEL_UP));
        checkValue("tie_lives", int'(bus.lives), 3);
        frames(LEVEL_F);
        press5();
        hitN(2);
        step(0, 1, 1);
        checkValue("tie_lost_state", int'(bus.gameState), int'(LOST));
        checkValue("tie_lost_score", int'(bus.score), 110);
        checkValue("sat_score", int'(bus2.score), SMAX2);
        frames(LOST_F);
        press5();
        pressPause();
        checkValue("paused", int'(bus.gameState), int'(PAUSED));
        hitN(3);
        checkValue("paused_score", int'(bus.score), 110);
        pressPause();
        step(0, 1, 0);
        frames(20);
        asyncReset();

        // Random play.
        for (int c = 0; c < 15000; c++) begin
            if (c == 7000) asyncReset();
            if ($urandom_range(0, 19) == 0) k5Lvl = !k5Lvl;
            if ($urandom_range(0, 29) == 0) kpLvl = !kpLvl;
            step(bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 49) == 0),
                 bit'($urandom_range(0, 4) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
